// File: rtl/pc_pkg.sv
// Shared types and constants for the PC predict unit.
//   ctr_e    : 2-bit branch direction counter (SNT, WNT, WT, ST)
//   state_e  : fetch FSM state (BOOT, RUN)
//   INSTR_BYTES : sequential fetch stride in bytes
//   ctr_inc / ctr_dec : saturating counter helpers
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int INSTR_BYTES = 4;

  // Saturating increment toward strongly-taken.
  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      SNT:     ctr_inc = WNT;
      WNT:     ctr_inc = WT;
      WT:      ctr_inc = ST;
      ST:      ctr_inc = ST;
      default: ctr_inc = WNT;
    endcase
  endfunction

  // Saturating decrement toward strongly-not-taken.
  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      SNT:     ctr_dec = SNT;
      WNT:     ctr_dec = SNT;
      WT:      ctr_dec = WNT;
      ST:      ctr_dec = WT;
      default: ctr_dec = WNT;
    endcase
  endfunction

  // A counter at WT or above predicts taken.
  function automatic logic ctr_taken(input ctr_e c);
    ctr_taken = (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer.
//   clk, rst          : clock, async active-low reset (clears valids, counters to WNT)
//   lookup_pc         : address looked up combinationally
//   lookup_taken      : hit with a taken-leaning counter
//   lookup_target     : stored target of the indexed entry
//   upd_valid/upd_pc/upd_taken/upd_target : resolved branch training
// Lookups read the registered array, so a same-cycle update to the same
// index is only visible from the following cycle.
module pc_btb
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             lookup_taken,
  output logic [WIDTH-1:0] lookup_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic             valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
  logic [WIDTH-1:0] target_q [BTB_DEPTH];
  ctr_e             ctr_q    [BTB_DEPTH];

  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX-1:0]   up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;

  logic             we_s;
  logic [WIDTH-1:0] wr_target_s;
  ctr_e             wr_ctr_s;

  // Instruction addresses are word aligned; the low bits carry no index/tag information.
  logic unused_low_s;
  assign unused_low_s = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx_s = lookup_pc[IDX+1:2];
  assign lk_tag_s = lookup_pc[WIDTH-1:IDX+2];
  assign up_idx_s = upd_pc[IDX+1:2];
  assign up_tag_s = upd_pc[WIDTH-1:IDX+2];

  assign lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);

  assign lookup_taken  = lk_hit_s && ctr_taken(ctr_q[lk_idx_s]);
  assign lookup_target = target_q[lk_idx_s];

  // Training decision: what (if anything) gets written to the indexed entry.
  always_comb begin
    we_s        = 1'b0;
    wr_target_s = target_q[up_idx_s];
    wr_ctr_s    = ctr_q[up_idx_s];
    if (upd_valid) begin
      if (upd_taken) begin
        we_s        = 1'b1;
        wr_target_s = upd_target;
        wr_ctr_s    = up_hit_s ? ctr_inc(ctr_q[up_idx_s]) : WT;
      end else if (up_hit_s) begin
        we_s     = 1'b1;
        wr_ctr_s = ctr_dec(ctr_q[up_idx_s]);
      end else begin
        we_s = 1'b0;
      end
    end else begin
      we_s = 1'b0;
    end
  end

  // BTB storage with async clear of every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (we_s) begin
      valid_q[up_idx_s]  <= 1'b1;
      tag_q[up_idx_s]    <= up_tag_s;
      target_q[up_idx_s] <= wr_target_s;
      ctr_q[up_idx_s]    <= wr_ctr_s;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC generator with BTB-based next-PC prediction.
//   clk, rst        : clock, async active-low reset
//   fetch_ready     : fetch stage accepts pc_out this cycle
//   fetch_valid     : pc_out is a valid fetch address (0 during BOOT)
//   pc_out          : current fetch PC
//   pred_taken      : next PC for pc_out comes from a BTB prediction
//   redirect/redirect_pc : execute-stage correction, word-aligned on load
//   upd_*           : resolved branch training forwarded to the BTB
//   misalign        : one-cycle pulse after a redirect with redirect_pc[1:0] != 0
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int               BTB_DEPTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic             pred_taken,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  output logic             misalign
);

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             fetch_valid_q;
  logic             misalign_q;

  logic             btb_taken_s;
  logic [WIDTH-1:0] btb_target_s;

  pc_btb #(
    .WIDTH     (WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .lookup_taken  (btb_taken_s),
    .lookup_target (btb_target_s),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  // Next-PC mux: redirect beats stall, stall beats prediction; BOOT holds the reset vector.
  always_comb begin
    pc_d = pc_q;
    if (state_q == RUN) begin
      if (redirect) begin
        pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      end else if (fetch_ready) begin
        pc_d = btb_taken_s ? btb_target_s : (pc_q + WIDTH'(INSTR_BYTES));
      end else begin
        pc_d = pc_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // BOOT/RUN FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
          misalign_q    <= 1'b0;
          pc_q          <= pc_d;
        end
        RUN: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
          misalign_q    <= redirect && (redirect_pc[1:0] != 2'b00);
          pc_q          <= pc_d;
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
          misalign_q    <= 1'b0;
          pc_q          <= RESET_VECTOR;
        end
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc_out      = pc_q;
  assign misalign    = misalign_q;
  // Lookup is only meaningful once fetch is live.
  assign pred_taken  = fetch_valid_q && btb_taken_s;

endmodule
